// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback sources share the regfile's single write port. Each source has a
// small FIFO. A has fixed priority over B, and a starvation counter eventually
// forces B through. A combinational query reports queued writes so decode can
// stall on RAW hazards.
// Optional build macro WB_BYPASS_EN: when the A FIFO is empty and A would win,
// an incoming A request goes straight into the output registers and skips its FIFO.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  chk_addr,
  output logic        chk_hit,
  output logic        busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    a_addr_q [DEPTH];
  logic [31:0]   a_data_q [DEPTH];
  logic [4:0]    b_addr_q [DEPTH];
  logic [31:0]   b_data_q [DEPTH];
  logic [PW-1:0] a_wptr_q, a_rptr_q, b_wptr_q, b_rptr_q;
  logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic a_ne, b_ne, a_cand, byp_req, bypass;
  logic a_win, b_win, a_push, b_push;
  logic starved;

  assign a_ready = (a_cnt_q != CW'(DEPTH));
  assign b_ready = (b_cnt_q != CW'(DEPTH));
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = (a_cnt_q != '0) || (b_cnt_q != '0) || rf_we_q;

  // Arbitration: B wins when A has nothing or B has waited long enough.
  always_comb begin
    a_ne    = (a_cnt_q != '0);
    b_ne    = (b_cnt_q != '0);
`ifdef WB_BYPASS_EN
    byp_req = !a_ne && a_valid && (a_addr != 5'd0);
`else
    byp_req = 1'b0;
`endif
    a_cand  = a_ne || byp_req;
    starved = (starve_q >= SW'(STARVE_LIMIT));
    b_win   = b_ne && (!a_cand || starved);
    a_win   = a_ne && !b_win;
    bypass  = byp_req && !b_win;
    // Writes to x0 complete the handshake but are dropped here.
    a_push  = a_valid && a_ready && (a_addr != 5'd0) && !bypass;
    b_push  = b_valid && b_ready && (b_addr != 5'd0);
  end

  // Next-state for FIFO occupancy, starvation counter and output stage.
  always_comb begin
    a_cnt_d = a_cnt_q + (a_push ? CW'(1) : CW'(0)) - (a_win ? CW'(1) : CW'(0));
    b_cnt_d = b_cnt_q + (b_push ? CW'(1) : CW'(0)) - (b_win ? CW'(1) : CW'(0));
    if (b_ne && (a_win || bypass)) begin
      starve_d = starved ? starve_q : starve_q + SW'(1);
    end else begin
      starve_d = '0;
    end
    rf_we_d    = a_win || b_win || bypass;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (b_win) begin
      rf_waddr_d = b_addr_q[b_rptr_q];
      rf_wdata_d = b_data_q[b_rptr_q];
    end else if (a_win) begin
      rf_waddr_d = a_addr_q[a_rptr_q];
      rf_wdata_d = a_data_q[a_rptr_q];
    end else if (bypass) begin
      rf_waddr_d = a_addr;
      rf_wdata_d = a_data;
    end
  end

  // Control state: pointers, counts, starvation counter, write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wptr_q   <= '0;
      a_rptr_q   <= '0;
      b_wptr_q   <= '0;
      b_rptr_q   <= '0;
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (a_push) a_wptr_q <= a_wptr_q + PW'(1);
      if (a_win)  a_rptr_q <= a_rptr_q + PW'(1);
      if (b_push) b_wptr_q <= b_wptr_q + PW'(1);
      if (b_win)  b_rptr_q <= b_rptr_q + PW'(1);
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO storage; validity is tracked by the counts, so no reset is needed.
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_addr_q[a_wptr_q] <= a_addr;
      a_data_q[a_wptr_q] <= a_data;
    end
    if (b_push) begin
      b_addr_q[b_wptr_q] <= b_addr;
      b_data_q[b_wptr_q] <= b_data;
    end
  end

  // Hazard query over live FIFO entries, the output stage and a bypassing request.
  always_comb begin
    logic [PW-1:0] idx;
    chk_hit = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = a_rptr_q + PW'(k);
      if ((CW'(k) < a_cnt_q) && (a_addr_q[idx] == chk_addr)) chk_hit = 1'b1;
      idx = b_rptr_q + PW'(k);
      if ((CW'(k) < b_cnt_q) && (b_addr_q[idx] == chk_addr)) chk_hit = 1'b1;
    end
    if (rf_we_q && (rf_waddr_q == chk_addr)) chk_hit = 1'b1;
    if (bypass && (a_addr == chk_addr)) chk_hit = 1'b1;
    if (chk_addr == 5'd0) chk_hit = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter (default build, FIFO path for every write).
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr = '0, b_addr = '0, chk_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_we, chk_hit, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every regfile write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, want no write",
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL write_stream: got addr %0d data %h, want addr %0d data %h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    int  ai, bj;
    logic ar, br;

    // Reset state
    #2;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_chk_hit", chk_hit, 0);
    #10 rst = 1'b0;
    #1;
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    step();

    // Single A write: two-edge latency through the FIFO
    expect_wr(5'd5, 32'h1234_5678);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678; chk_addr = 5'd5;
    step();
    a_valid = 1'b0;
    check("a1_we_early", rf_we, 0);
    check("a1_busy", busy, 1);
    check("a1_chk_queued", chk_hit, 1);
    step();
    check("a1_we", rf_we, 1);
    check("a1_waddr", rf_waddr, 5);
    check("a1_wdata", rf_wdata, 32'h1234_5678);
    step();
    check("a1_we_done", rf_we, 0);
    check("a1_busy_done", busy, 0);

    // Zero register: handshake completes, nothing queued
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF; chk_addr = 5'd0;
    #1;
    check("x0_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    check("x0_chk_hit", chk_hit, 0);
    check("x0_busy", busy, 0);
    check("x0_we", rf_we, 0);
    step();
    check("x0_we_late", rf_we, 0);
    check("x0_waddr_hold", rf_waddr, 5);
    check("x0_wdata_hold", rf_wdata, 32'h1234_5678);

    // Full B FIFO under saturating A, with starvation relief every 5th cycle
    for (int g = 0; g < 3; g++) begin
      for (int m = 0; m < 4; m++) expect_wr(5'd7, 32'hA000_0000 + 32'(4 * g + m));
      expect_wr(5'(g + 1), 32'hB000_0000 + 32'(g + 1));
    end
    expect_wr(5'd7, 32'hA000_000C);
    expect_wr(5'd7, 32'hA000_000D);
    ai = 0;
    bj = 0;
    for (int e = 0; e < 18; e++) begin
      a_valid = (e < 16);
      a_addr  = 5'd7;
      a_data  = 32'hA000_0000 + 32'(ai);
      b_valid = (bj < 3);
      b_addr  = 5'(bj + 1);
      b_data  = 32'hB000_0000 + 32'(bj + 1);
      ar = a_ready;
      br = b_ready;
      step();
      if (a_valid && ar) ai++;
      if (b_valid && br) bj++;
      case (e)
        1: check("full_b_ready_low", b_ready, 0);
        4: check("starve_a_before", rf_waddr, 7);
        5: begin
          check("starve_b_wins", rf_waddr, 1);
          check("starve_a_full", a_ready, 0);
          check("full_b_ready_back", b_ready, 1);
        end
        6: begin
          check("starve_a_resumes", rf_waddr, 7);
          check("full_b_ready_refill", b_ready, 0);
        end
        10: check("starve_b2_wins", rf_waddr, 2);
        default: ;
      endcase
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("full_a_accepts", 32'(ai), 14);
    check("full_b_accepts", 32'(bj), 3);
    step();
    check("full_drained_busy", busy, 0);

    // Hazard: queued B write to x12
    expect_wr(5'd12, 32'hC0DE_000C);
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hC0DE_000C; chk_addr = 5'd12;
    #1;
    check("haz_before_accept", chk_hit, 0);
    step();
    b_valid = 1'b0;
    check("haz_queued", chk_hit, 1);
    chk_addr = 5'd13;
    #1;
    check("haz_other_reg", chk_hit, 0);
    chk_addr = 5'd12;
    step();
    check("haz_output_stage", chk_hit, 1);
    check("haz_we", rf_we, 1);
    step();
    check("haz_cleared", chk_hit, 0);

    // Reset mid-stream discards queued writes
    expect_wr(5'd20, 32'hD000_0000);
    a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hD000_0000;
    b_valid = 1'b1; b_addr = 5'd21; b_data = 32'hD000_0001;
    chk_addr = 5'd21;
    step();
    a_addr = 5'd22; a_data = 32'hD000_0002;
    b_valid = 1'b0;
    step();
    a_valid = 1'b0;
    check("mid_we", rf_we, 1);
    check("mid_busy", busy, 1);
    check("mid_chk_b", chk_hit, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we", rf_we, 0);
    check("mid_rst_waddr", rf_waddr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_chk", chk_hit, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_no_we", rf_we, 0);
      check("post_rst_busy", busy, 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
